// File: rtl/smem_bck_ctrl_stage_p.sv
// Backward-extension control stage of the SMEM pipeline: advances (bi,bj) and size/address
// bookkeeping per token behind a valid/ready handshake with a one-deep skid behind the output register.
module smem_bck_ctrl_stage_p #(
  parameter int RD_W   = 6,
  parameter int AW     = 7,
  parameter int DW     = 64,
  parameter int INFO_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_status,
  input  logic [RD_W-1:0]   in_read_num,
  input  logic [AW-1:0]     in_rd_addr,
  input  logic [AW-1:0]     in_wr_addr,
  input  logic [AW-1:0]     in_mem_wr_addr,
  input  logic [AW-1:0]     in_fwd_size,
  input  logic [AW-1:0]     in_new_size,
  input  logic [AW-1:0]     in_last_size,
  input  logic [AW-1:0]     in_bi,
  input  logic [AW-1:0]     in_bj,
  input  logic [7:0]        in_c,
  input  logic [AW-1:0]     in_min_intv,
  input  logic              in_iter_bnd,
  input  logic              in_last_read,
  input  logic [DW-1:0]     in_primary,
  input  logic [DW-1:0]     in_tok,
  input  logic [INFO_W-1:0] in_info,
  input  logic [4*DW-1:0]   in_pend,
  output logic [5:0]        out_status,
  output logic [RD_W-1:0]   out_read_num,
  output logic [AW-1:0]     out_rd_addr,
  output logic [AW-1:0]     out_wr_addr,
  output logic [AW-1:0]     out_mem_wr_addr,
  output logic [AW-1:0]     out_fwd_size,
  output logic [AW-1:0]     out_new_size,
  output logic [AW-1:0]     out_last_size,
  output logic [AW-1:0]     out_bi,
  output logic [AW-1:0]     out_bj,
  output logic [7:0]        out_c,
  output logic [AW-1:0]     out_min_intv,
  output logic              out_iter_bnd,
  output logic              out_last_read,
  output logic [DW-1:0]     out_primary,
  output logic [DW-1:0]     out_tok,
  output logic [INFO_W-1:0] out_info,
  output logic [4*DW-1:0]   out_pend,
  output logic              out_finish,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_run,
  output logic [CNT_W-1:0]  cnt_bubble,
  output logic              err_status
);

  localparam logic [5:0] ST_BUBBLE  = 6'h00;
  localparam logic [5:0] ST_F_INIT  = 6'h01;
  localparam logic [5:0] ST_F_RUN   = 6'h02;
  localparam logic [5:0] ST_F_BREAK = 6'h04;
  localparam logic [5:0] ST_BCK_INI = 6'h08;
  localparam logic [5:0] ST_BCK_RUN = 6'h10;
  localparam logic [5:0] ST_BCK_END = 6'h20;

  typedef struct packed {
    logic [5:0]        status;
    logic [RD_W-1:0]   read_num;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     mem_wr_addr;
    logic [AW-1:0]     fwd_size;
    logic [AW-1:0]     new_size;
    logic [AW-1:0]     last_size;
    logic [AW-1:0]     bi;
    logic [AW-1:0]     bj;
    logic [7:0]        c;
    logic [AW-1:0]     min_intv;
    logic              iter_bnd;
    logic              last_read;
    logic [DW-1:0]     primary;
    logic [DW-1:0]     tok;
    logic [INFO_W-1:0] info;
    logic [4*DW-1:0]   pend;
    logic              finish;
  } tok_t;

  tok_t             r_out, r_skid, w_tok;
  logic             r_out_valid, r_skid_full, r_in_ready, r_err;
  logic [CNT_W-1:0] r_cnt_run, r_cnt_bubble;
  logic             w_acc, w_out_free, w_fire, w_legal;
  logic             w_jb, w_ib, w_ibn;
  logic [AW-1:0]    w_ls_m1;

  assign w_acc      = in_valid & r_in_ready;
  assign w_out_free = ~r_out_valid | out_ready;
  assign w_fire     = r_out_valid & out_ready;

  // j-boundary: j has reached the last column of the previous size (or there is none)
  assign w_ls_m1 = in_last_size - AW'(1);
  assign w_jb    = (in_last_size == '0) | (in_bj == w_ls_m1);
  assign w_ib    = w_jb & (in_bi != '0);
  assign w_ibn   = w_jb & (in_bi == '0);

  assign w_legal = (in_status == ST_BUBBLE)  | (in_status == ST_F_INIT)  |
                   (in_status == ST_F_RUN)   | (in_status == ST_F_BREAK) |
                   (in_status == ST_BCK_INI) | (in_status == ST_BCK_RUN) |
                   (in_status == ST_BCK_END);

  always_comb begin
    w_tok = '{status: in_status, read_num: in_read_num, rd_addr: in_rd_addr,
              wr_addr: in_wr_addr, mem_wr_addr: in_mem_wr_addr, fwd_size: in_fwd_size,
              new_size: in_new_size, last_size: in_last_size, bi: in_bi, bj: in_bj,
              c: in_c, min_intv: in_min_intv, iter_bnd: in_iter_bnd,
              last_read: in_last_read, primary: in_primary, tok: in_tok, info: in_info,
              pend: in_pend, finish: 1'b0};
    case (in_status)
      ST_BCK_INI: begin
        w_tok.c         = '0;
        w_tok.pend      = '0;
        w_tok.last_read = 1'b0;
      end
      ST_BCK_RUN: begin
        w_tok.bj        = w_jb ? '0 : in_bj + AW'(1);
        w_tok.bi        = in_iter_bnd ? '0 : (w_ib ? in_bi - AW'(1) : in_bi);
        w_tok.wr_addr   = w_jb ? in_fwd_size - AW'(1) : in_wr_addr;
        w_tok.last_size = w_jb ? in_new_size : in_last_size;
        w_tok.new_size  = w_jb ? '0 : in_new_size;
        w_tok.finish    = w_jb & (in_new_size == '0);
        w_tok.iter_bnd  = in_iter_bnd | w_ibn;
      end
      default: w_tok = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_full  <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cnt_run    <= '0;
      r_cnt_bubble <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_out_free) begin
        r_in_ready <= 1'b1;
        if (r_skid_full) begin
          r_out       <= r_skid;
          r_out_valid <= 1'b1;
          r_skid_full <= 1'b0;
        end else if (w_acc) begin
          r_out       <= w_tok;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid      <= w_tok;
        r_skid_full <= 1'b1;
        r_in_ready  <= 1'b0;
      end else begin
        r_in_ready <= ~r_skid_full;
      end

      if (cnt_clr) begin
        r_cnt_run    <= '0;
        r_cnt_bubble <= '0;
        r_err        <= 1'b0;
      end else begin
        if (w_fire && r_out.status == ST_BCK_RUN && !(&r_cnt_run))
          r_cnt_run <= r_cnt_run + CNT_W'(1);
        if (w_fire && r_out.status == ST_BUBBLE && !(&r_cnt_bubble))
          r_cnt_bubble <= r_cnt_bubble + CNT_W'(1);
        if (w_acc && !w_legal)
          r_err <= 1'b1;
      end
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_valid;
  assign out_status      = r_out.status;
  assign out_read_num    = r_out.read_num;
  assign out_rd_addr     = r_out.rd_addr;
  assign out_wr_addr     = r_out.wr_addr;
  assign out_mem_wr_addr = r_out.mem_wr_addr;
  assign out_fwd_size    = r_out.fwd_size;
  assign out_new_size    = r_out.new_size;
  assign out_last_size   = r_out.last_size;
  assign out_bi          = r_out.bi;
  assign out_bj          = r_out.bj;
  assign out_c           = r_out.c;
  assign out_min_intv    = r_out.min_intv;
  assign out_iter_bnd    = r_out.iter_bnd;
  assign out_last_read   = r_out.last_read;
  assign out_primary     = r_out.primary;
  assign out_tok         = r_out.tok;
  assign out_info        = r_out.info;
  assign out_pend        = r_out.pend;
  assign out_finish      = r_out.finish;
  assign cnt_run         = r_cnt_run;
  assign cnt_bubble      = r_cnt_bubble;
  assign err_status      = r_err;

endmodule

// File: tb/tb_smem_bck_ctrl_stage_p.sv
// Directed bench for smem_bck_ctrl_stage_p: field transforms, skid backpressure, bubbles, counters, reset.
module tb_smem_bck_ctrl_stage_p;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   in_status;
  logic [5:0]   in_read_num;
  logic [6:0]   in_rd_addr, in_wr_addr, in_mem_wr_addr, in_fwd_size, in_new_size, in_last_size;
  logic [6:0]   in_bi, in_bj, in_min_intv;
  logic [7:0]   in_c;
  logic         in_iter_bnd, in_last_read;
  logic [63:0]  in_primary, in_tok;
  logic [31:0]  in_info;
  logic [255:0] in_pend;
  logic [5:0]   out_status;
  logic [5:0]   out_read_num;
  logic [6:0]   out_rd_addr, out_wr_addr, out_mem_wr_addr, out_fwd_size, out_new_size, out_last_size;
  logic [6:0]   out_bi, out_bj, out_min_intv;
  logic [7:0]   out_c;
  logic         out_iter_bnd, out_last_read, out_finish, out_valid;
  logic [63:0]  out_primary, out_tok;
  logic [31:0]  out_info;
  logic [255:0] out_pend;
  logic         out_ready = 1'b1;
  logic         cnt_clr = 1'b0;
  logic [31:0]  cnt_run, cnt_bubble;
  logic         err_status;

  int n_total = 0;
  int n_bad   = 0;
  logic [6:0] got_q[$];
  logic rec_en = 1'b0;
  logic saw_low, t4_timeout;

  localparam logic [5:0] BCK_INI = 6'h08;
  localparam logic [5:0] BCK_RUN = 6'h10;
  localparam logic [255:0] PEND_DEF = {4{64'h0123_4567_89AB_CDEF}};

  smem_bck_ctrl_stage_p dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_status(in_status), .in_read_num(in_read_num), .in_rd_addr(in_rd_addr),
    .in_wr_addr(in_wr_addr), .in_mem_wr_addr(in_mem_wr_addr), .in_fwd_size(in_fwd_size),
    .in_new_size(in_new_size), .in_last_size(in_last_size), .in_bi(in_bi), .in_bj(in_bj),
    .in_c(in_c), .in_min_intv(in_min_intv), .in_iter_bnd(in_iter_bnd),
    .in_last_read(in_last_read), .in_primary(in_primary), .in_tok(in_tok),
    .in_info(in_info), .in_pend(in_pend),
    .out_status(out_status), .out_read_num(out_read_num), .out_rd_addr(out_rd_addr),
    .out_wr_addr(out_wr_addr), .out_mem_wr_addr(out_mem_wr_addr),
    .out_fwd_size(out_fwd_size), .out_new_size(out_new_size),
    .out_last_size(out_last_size), .out_bi(out_bi), .out_bj(out_bj), .out_c(out_c),
    .out_min_intv(out_min_intv), .out_iter_bnd(out_iter_bnd),
    .out_last_read(out_last_read), .out_primary(out_primary), .out_tok(out_tok),
    .out_info(out_info), .out_pend(out_pend), .out_finish(out_finish),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
    .cnt_run(cnt_run), .cnt_bubble(cnt_bubble), .err_status(err_status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // one line per output token transferred
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      $display("txn out status=%02h bi=%0d bj=%0d finish=%0d", out_status, out_bi, out_bj, out_finish);
      if (rec_en) got_q.push_back(out_bj);
    end
  end

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tok(input logic [5:0] st, input logic [6:0] bi, input logic [6:0] bj,
                         input logic [6:0] ls, input logic [6:0] ns, input logic [6:0] fwd,
                         input logic ib);
    in_status = st;       in_bi = bi;           in_bj = bj;
    in_last_size = ls;    in_new_size = ns;     in_fwd_size = fwd;
    in_iter_bnd = ib;     in_read_num = 6'h15;  in_rd_addr = 7'h11;
    in_wr_addr = 7'h22;   in_mem_wr_addr = 7'h33; in_c = 8'h41;
    in_min_intv = 7'h0c;  in_last_read = 1'b1;  in_primary = 64'hA5A5_0000_FFFF_1234;
    in_tok = 64'h0BAD_F00D_CAFE_0001; in_info = 32'hDEAD_BEEF; in_pend = PEND_DEF;
  endtask

  // present one token for a single cycle; outputs show it on return
  task automatic send();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    set_tok(6'h00, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    #1;
    chk_eq("rst_out_valid", out_valid, 1'b0);
    chk_eq("rst_out_status", out_status, 6'h00);
    chk_eq("rst_cnt_run", cnt_run, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk_eq("rst_in_ready", in_ready, 1'b1);

    // 1: j boundary with i decrement
    set_tok(BCK_RUN, 7'd5, 7'd2, 7'd3, 7'd4, 7'd10, 1'b0);
    send();
    chk_eq("t1_valid", out_valid, 1'b1);
    chk_eq("t1_bj", out_bj, 7'd0);
    chk_eq("t1_bi", out_bi, 7'd4);
    chk_eq("t1_wr", out_wr_addr, 7'd9);
    chk_eq("t1_last", out_last_size, 7'd4);
    chk_eq("t1_new", out_new_size, 7'd0);
    chk_eq("t1_finish", out_finish, 1'b0);
    chk_eq("t1_pass", {out_rd_addr, out_c, out_pend[63:0], out_info}, {7'h11, 8'h41, PEND_DEF[63:0], 32'hDEAD_BEEF});

    // no j boundary: j advances, sizes untouched
    set_tok(BCK_RUN, 7'd5, 7'd1, 7'd4, 7'd4, 7'd10, 1'b0);
    send();
    chk_eq("tj_bj", out_bj, 7'd2);
    chk_eq("tj_bi_wr", {out_bi, out_wr_addr, out_last_size, out_new_size}, {7'd5, 7'h22, 7'd4, 7'd4});
    chk_eq("tj_fin_it", {out_finish, out_iter_bnd}, 2'b00);

    // 2: finish with i at zero, then iteration boundary already set
    set_tok(BCK_RUN, 7'd0, 7'd6, 7'd7, 7'd0, 7'd10, 1'b0);
    send();
    chk_eq("t2a_fin_it_bj", {out_finish, out_iter_bnd, out_bj, out_bi}, {1'b1, 1'b1, 7'd0, 7'd0});
    set_tok(BCK_RUN, 7'd3, 7'd6, 7'd7, 7'd0, 7'd10, 1'b1);
    send();
    chk_eq("t2b_bi", out_bi, 7'd0);
    chk_eq("t2b_fin_it", {out_finish, out_iter_bnd}, 2'b11);

    // empty last size is a j boundary; fwd_size-1 wraps
    set_tok(BCK_RUN, 7'd2, 7'd5, 7'd0, 7'd3, 7'd0, 1'b0);
    send();
    chk_eq("tz_fields", {out_bj, out_bi, out_wr_addr, out_last_size, out_new_size, out_finish},
           {7'd0, 7'd1, 7'h7F, 7'd3, 7'd0, 1'b0});

    // 3: BCK_INI clears c/pend/last_read, passes the rest
    set_tok(BCK_INI, 7'd5, 7'd2, 7'd3, 7'd4, 7'd10, 1'b0);
    in_pend = '1;
    send();
    chk_eq("t3_status", out_status, BCK_INI);
    chk_eq("t3_cleared", {out_c, out_last_read, out_finish}, 10'd0);
    chk_eq("t3_pend", out_pend, 256'd0);
    chk_eq("t3_pass", {out_bi, out_bj, out_last_size, out_new_size, out_wr_addr, out_read_num, out_primary},
           {7'd5, 7'd2, 7'd3, 7'd4, 7'h22, 6'h15, 64'hA5A5_0000_FFFF_1234});
    step();
    chk_eq("t3_cnt_run", cnt_run, 32'd5);
    chk_eq("t3_cnt_bub", cnt_bubble, 32'd0);

    // 4: four-token burst against a 3-cycle stall
    out_ready = 1'b0;
    got_q.delete();
    rec_en = 1'b1;
    saw_low = 1'b0;
    t4_timeout = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          int tries;
          logic acc;
          tries = 0;
          acc = 1'b0;
          set_tok(BCK_INI, 7'd1, 7'(k + 1), 7'd3, 7'd4, 7'd10, 1'b0);
          in_valid = 1'b1;
          while (!acc && tries < 20) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else saw_low = 1'b1;
            step();
            tries++;
          end
          if (!acc) t4_timeout = 1'b1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    rec_en = 1'b0;
    chk_eq("t4_timeout", t4_timeout, 1'b0);
    chk_eq("t4_ready_low", saw_low, 1'b1);
    chk_eq("t4_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      chk_eq($sformatf("t4_order%0d", k), got_q[k], 7'(k + 1));

    // 5: illegal status and non-backward status both become bubbles
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    set_tok(6'b000011, 7'd5, 7'd2, 7'd3, 7'd4, 7'd10, 1'b0);
    send();
    chk_eq("t5_bubble", {out_status, out_bi, out_bj, out_primary, out_c}, 256'd0);
    chk_eq("t5_valid", out_valid, 1'b1);
    chk_eq("t5_err", err_status, 1'b1);
    set_tok(6'h02, 7'd5, 7'd2, 7'd3, 7'd4, 7'd10, 1'b0);
    send();
    step();
    chk_eq("t5_cnt_bub", cnt_bubble, 32'd2);
    chk_eq("t5_cnt_run", cnt_run, 32'd0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk_eq("t5_clr", {cnt_run, cnt_bubble, err_status}, 65'd0);

    // 6: reset with the skid full
    set_tok(BCK_RUN, 7'd5, 7'd2, 7'd3, 7'd4, 7'd10, 1'b0);
    send();
    step();
    chk_eq("t6_cnt_run", cnt_run, 32'd1);
    out_ready = 1'b0;
    set_tok(BCK_INI, 7'd1, 7'd1, 7'd3, 7'd4, 7'd10, 1'b0);
    send();
    set_tok(BCK_INI, 7'd1, 7'd2, 7'd3, 7'd4, 7'd10, 1'b0);
    send();
    chk_eq("t6_full_ready", in_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("t6_rst_valid", out_valid, 1'b0);
    chk_eq("t6_rst_cnt", cnt_run, 32'd0);
    step(); step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk_eq("t6_ready", in_ready, 1'b1);
    chk_eq("t6_valid", out_valid, 1'b0);
    chk_eq("t6_cnts", {cnt_run, cnt_bubble, err_status}, 65'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
